// File: rtl/xbar_switch.sv
// xbar_switch: NP x NP registered crossbar with per-output round-robin
// arbitration and a one-entry output slot per output port.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_DATA    NP*WL  input words, port i at [i*WL +: WL]
//   IN_DEST    NP*SW  destination output per input, port i at [i*SW +: SW]
//   IN_VALID   NP     input word valid
//   IN_READY   NP     input word accepted this cycle (combinational)
//   OUT_DATA   NP*WL  output words, same packing as IN_DATA
//   OUT_SRC    NP*SW  input index that supplied each output word
//   OUT_VALID  NP     output slot valid
//   OUT_READY  NP     consumer accepts the output word
module xbar_switch #(
  parameter int WL = 16,
  parameter int NP = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NP*WL-1:0]           IN_DATA,
  input  logic [NP*$clog2(NP)-1:0]   IN_DEST,
  input  logic [NP-1:0]              IN_VALID,
  output logic [NP-1:0]              IN_READY,
  output logic [NP*WL-1:0]           OUT_DATA,
  output logic [NP*$clog2(NP)-1:0]   OUT_SRC,
  output logic [NP-1:0]              OUT_VALID,
  input  logic [NP-1:0]              OUT_READY
);

  localparam int SW = $clog2(NP);

  logic [SW-1:0] ptr     [NP];
  logic [WL-1:0] data_q  [NP];
  logic [SW-1:0] src_q   [NP];
  logic [NP-1:0] valid_q;

  logic [NP-1:0] can_load;
  logic [NP-1:0] gnt_any;
  logic [SW-1:0] gnt_idx [NP];

  // Arbitration: for each output, scan inputs starting at its pointer.
  // NP is a power of two, so SW-bit addition wraps modulo NP for free.
  always_comb begin
    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] win;
    for (int unsigned j = 0; j < NP; j++) begin
      can_load[j] = !valid_q[j] || OUT_READY[j];
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 0; k < NP; k++) begin
        idx = ptr[j] + SW'(k);
        if (!found && IN_VALID[idx] && (IN_DEST[idx*SW +: SW] == SW'(j))) begin
          found = 1'b1;
          win   = idx;
        end
      end
      gnt_any[j] = found && can_load[j];
      gnt_idx[j] = win;
    end
  end

  // An input is ready only when the output it targets grants it; gated by
  // reset so no acceptance can be reported while the slots are cleared.
  always_comb begin
    logic [SW-1:0] d;
    for (int unsigned i = 0; i < NP; i++) begin
      d           = IN_DEST[i*SW +: SW];
      IN_READY[i] = RST_N && IN_VALID[i] && gnt_any[d] && (gnt_idx[d] == SW'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      for (int unsigned j = 0; j < NP; j++) begin
        ptr[j]    <= '0;
        data_q[j] <= '0;
        src_q[j]  <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NP; j++) begin
        if (gnt_any[j]) begin
          data_q[j]  <= IN_DATA[gnt_idx[j]*WL +: WL];
          src_q[j]   <= gnt_idx[j];
          valid_q[j] <= 1'b1;
          ptr[j]     <= gnt_idx[j] + SW'(1);
        end else if (OUT_READY[j]) begin
          valid_q[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NP; j++) begin
      OUT_DATA[j*WL +: WL] = data_q[j];
      OUT_SRC[j*SW +: SW]  = src_q[j];
    end
    OUT_VALID = valid_q;
  end

endmodule

// File: doc/xbar_switch.md
# xbar_switch

- Parametrised NP-port by NP-port registered crossbar switch. Successor to the static 4x4 select-driven crossbar.
- Each input presents a word tagged with a destination port. Each output arbitrates round-robin among the inputs targeting it and buffers the winner in a one-entry output register.
- All ports use a valid/ready handshake.
- Sits between the datapath producers and consumers wherever the routing changes every cycle instead of being set by static selects.

## Interface

- WL, 16: data word width in bits.
- NP, 4: number of input ports and of output ports. Power of two, 2..8.
- SW, log2(NP): destination/source index width. Derived from NP; not to be overridden.

- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_DATA  in  NP*WL  input words; port i occupies bits [i*WL +: WL].
- IN_DEST  in  NP*SW  destination output index per input; port i occupies bits [i*SW +: SW].
- IN_VALID  in  NP  input word valid, one bit per input.
- IN_READY  out  NP  input word accepted this cycle, one bit per input.
- OUT_DATA  out  NP*WL  output words, same packing as IN_DATA.
- OUT_SRC  out  NP*SW  index of the input that supplied each output word.
- OUT_VALID  out  NP  output word valid, one bit per output.
- OUT_READY  in  NP  consumer accepts the output word, one bit per output.

## Operation

- **Per-output slot:** one register per output holding {data, src, valid}.
  - can_load[j] = !OUT_VALID[j] || OUT_READY[j].
- **Requests:** req[j][i] = IN_VALID[i] && IN_DEST[i]==j.
  - An input requests exactly one output per cycle.
- **Arbiter per output j:** round-robin pointer PTR[j] (SW bits).
  - Grant goes to the first requesting i, searching PTR[j], PTR[j]+1, ... modulo NP.
  - Grant is issued only if can_load[j].
- **On grant of input g to output j:**
  - OUT_DATA[j] <= IN_DATA[g]; OUT_SRC[j] <= g; OUT_VALID[j] <= 1.
  - PTR[j] <= (g+1) mod NP.
- **No grant and OUT_READY[j]:** OUT_VALID[j] <= 0. Data and src hold their last value.
- **No grant and not can_load[j]:** the slot holds and PTR[j] is unchanged.
- **No requesters:** PTR[j] is unchanged.
- **IN_READY[i]:** 1 exactly when input i is granted by output IN_DEST[i].
  - It is combinational from IN_VALID, IN_DEST, OUT_VALID, OUT_READY and PTR.
  - It is never 1 while IN_VALID[i] is 0.
  - It is forced to 0 while RST_N is low.
- **Producer rules:** IN_DATA and IN_DEST hold while IN_VALID && !IN_READY. IN_VALID does not deassert before acceptance.
- **Consumer-side guarantee:** OUT_DATA, OUT_SRC and OUT_VALID hold while OUT_VALID && !OUT_READY.
- **Outputs are independent:** different outputs may grant different inputs in the same cycle. All NP transfers in one cycle are legal.
- **Fairness:** with k persistent requesters on one output and OUT_READY held at 1, each requester is granted exactly once in every k consecutive grants.

## Timing

- Latency is 1 cycle. A word accepted at edge n appears on OUT_DATA/OUT_VALID after edge n.
- Throughput is one word per output per cycle while OUT_READY=1. The slot reloads in the same cycle it drains.
- **Reset values (asynchronous, immediate):** OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, all PTR=0, IN_READY=0.
- **Reset mid-operation:** buffered words are discarded and no grant is in flight.
  - After RST_N rises, the first rising edge may grant. PTR=0 favours input 0.
- **Pointer wrap:** a grant to input NP-1 sets PTR to 0.
- **Simultaneous drain and request:** OUT_READY=1 with OUT_VALID=1 and a pending request loads the new word. OUT_VALID stays 1 with no bubble.
- **Full slot, OUT_READY=0:** no input targeting that output is readied. Other outputs are unaffected (no head-of-line coupling across outputs).

## Test plan

- **Reset:** assert RST_N=0 mid-traffic with OUT_VALID[2]=1.
  - Immediately OUT_VALID=0000, IN_READY=0000, OUT_DATA=0.
  - After release, input 0 to output 3 with 0x00A5 gives OUT_DATA[3]=0x00A5 and OUT_SRC[3]=0 one cycle later.
- **Full permutation:** NP=4, inputs 0..3 send to outputs 3,2,1,0 with data 0x1000+i, all OUT_READY=1.
  - All IN_READY=1 every cycle.
  - Each cycle OUT_DATA[3-i]=0x1000+i and OUT_SRC[3-i]=i.
- **Contention fairness:** inputs 0,1,3 continuously send to output 1, OUT_READY[1]=1.
  - OUT_SRC[1] sequence is 0,1,3,0,1,3...
  - IN_READY for each of those inputs is high exactly one cycle in three.
- **Backpressure:** output 2 holds 0x0BEE, OUT_READY[2]=0 for 5 cycles while input 1 requests output 2.
  - OUT_DATA[2] stays 0x0BEE and IN_READY[1]=0 for those cycles.
  - When OUT_READY[2] returns to 1, input 1's word appears the next cycle with no bubble.
- **Independence:** output 0 stalled with OUT_READY[0]=0 and full. Input 2 targets output 1.
  - Input 2 flows at one word per cycle to output 1, unaffected.
- **Wrap and idle:** single requester input 3 to output 0, then idle for 3 cycles, then inputs 0 and 3 both request output 0.
  - PTR[0] is 0 after the wrap, so input 0 wins first, then input 3.
